pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register for the EX->MEM boundary and any later stage boundary.

---
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. Control bits are gated to zero on bubbles.
module pipe_stage_skid #(
    parameter int DATA_W = 104,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Encoding doubles as the occupancy count exposed on o_occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_acc;
    logic                w_rel;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;
    logic                w_stall;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // o_ready is a register output and never looks at i_ready.
    assign o_valid     = (r_state != ST_EMPTY);
    assign o_ready     = r_ready;
    assign w_acc       = i_valid & r_ready;
    assign w_rel       = o_valid & i_ready;
    assign w_stall     = o_valid & ~i_ready;
    assign o_data      = r_main_data;
    assign o_ctrl      = o_valid ? r_main_ctrl : '0;
    assign o_occupancy = r_state;
    assign o_stall_cnt = r_stall_cnt;

    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_next         = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({w_acc, w_rel})
                        2'b11: w_load_main_in = 1'b1;
                        2'b10: begin
                            w_next      = ST_FULL;
                            w_load_skid = 1'b1;
                        end
                        2'b01: w_next = ST_EMPTY;
                        default: w_next = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (w_rel) begin
                        w_next           = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_EMPTY;
            r_ready     <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != ST_FULL);
            if (w_load_main_in) begin
                r_main_data <= i_data;
                r_main_ctrl <= i_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
                r_skid_ctrl <= i_ctrl;
            end
        end
    end

    // Saturating stall counter; flush does not touch it, only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded random checks of pipe_stage_skid (DATA_W=16, CTRL_W=4, CNT_W=4).
module tb_pipe_stage_skid;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic              i_clk;
    logic              i_rst;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [CTRL_W-1:0] i_ctrl;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CTRL_W-1:0] o_ctrl;
    logic [1:0]        o_occupancy;
    logic [CNT_W-1:0]  o_stall_cnt;

    int n_total;
    int n_bad;
    logic [DATA_W+CTRL_W-1:0] exp_q[$];

    pipe_stage_skid #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_ctrl     (i_ctrl),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_occupancy(o_occupancy),
        .o_stall_cnt(o_stall_cnt)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst   = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_ctrl  = '0;
        repeat (2) tick();
        i_rst = 1'b1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        i_valid = 1'b1;
        i_data  = d;
        i_ctrl  = c;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;

        // reset state
        do_reset();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_ctrl", 32'(o_ctrl), 32'd0);
        chk("rst_occ", 32'(o_occupancy), 32'd0);
        chk("rst_stall", 32'(o_stall_cnt), 32'd0);

        // streaming
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data  = DATA_W'(i);
            i_ctrl  = CTRL_W'(i);
            tick();
            chk("str_valid", 32'(o_valid), 32'd1);
            chk("str_data", 32'(o_data), 32'(i));
            chk("str_occ", 32'(o_occupancy), 32'd1);
            chk("str_ready", 32'(o_ready), 32'd1);
        end
        i_valid = 1'b0;
        tick();
        chk("str_drain_valid", 32'(o_valid), 32'd0);
        chk("str_drain_ctrl", 32'(o_ctrl), 32'd0);
        chk("str_stall", 32'(o_stall_cnt), 32'd0);

        // back-pressure
        do_reset();
        push(16'h0011, 4'h1);
        chk("bp_one_ready", 32'(o_ready), 32'd1);
        chk("bp_one_occ", 32'(o_occupancy), 32'd1);
        push(16'h0022, 4'h2);
        chk("bp_full_occ", 32'(o_occupancy), 32'd2);
        chk("bp_full_ready", 32'(o_ready), 32'd0);
        chk("bp_full_data", 32'(o_data), 32'h11);
        tick();
        chk("bp_hold_data", 32'(o_data), 32'h11);
        chk("bp_hold_ctrl", 32'(o_ctrl), 32'h1);
        chk("bp_stall", 32'(o_stall_cnt), 32'd2);
        i_ready = 1'b1;
        tick();
        chk("bp_rel1_data", 32'(o_data), 32'h22);
        chk("bp_rel1_ctrl", 32'(o_ctrl), 32'h2);
        chk("bp_rel1_ready", 32'(o_ready), 32'd1);
        chk("bp_rel1_occ", 32'(o_occupancy), 32'd1);
        tick();
        chk("bp_rel2_valid", 32'(o_valid), 32'd0);
        chk("bp_stall_kept", 32'(o_stall_cnt), 32'd2);

        // flush while full with an incoming entry
        do_reset();
        push(16'h00a1, 4'hf);
        push(16'h00a2, 4'hf);
        chk("fl_pre_occ", 32'(o_occupancy), 32'd2);
        chk("fl_pre_ctrl", 32'(o_ctrl), 32'hf);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h0033;
        i_ctrl  = 4'hf;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ctrl", 32'(o_ctrl), 32'd0);
        chk("fl_occ", 32'(o_occupancy), 32'd0);
        chk("fl_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_0x33", 32'(o_valid), 32'd0);
        end

        // stall counter saturation
        do_reset();
        push(16'h0044, 4'h3);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_cnt", 32'(o_stall_cnt), 32'((k > 15) ? 15 : k));
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("sat_after_flush", 32'(o_stall_cnt), 32'd15);
        chk("sat_flush_valid", 32'(o_valid), 32'd0);

        // async reset between edges while full
        do_reset();
        push(16'h0066, 4'h5);
        push(16'h0077, 4'h6);
        tick();
        chk("ar_pre_occ", 32'(o_occupancy), 32'd2);
        #2;
        i_rst = 1'b0;
        #1;
        chk("ar_valid", 32'(o_valid), 32'd0);
        chk("ar_ready", 32'(o_ready), 32'd1);
        chk("ar_data", 32'(o_data), 32'd0);
        chk("ar_ctrl", 32'(o_ctrl), 32'd0);
        chk("ar_occ", 32'(o_occupancy), 32'd0);
        chk("ar_stall", 32'(o_stall_cnt), 32'd0);
        #1;
        i_rst   = 1'b1;
        i_ready = 1'b1;
        push(16'h0055, 4'h7);
        chk("ar_new_valid", 32'(o_valid), 32'd1);
        chk("ar_new_data", 32'(o_data), 32'h55);
        chk("ar_new_ctrl", 32'(o_ctrl), 32'h7);
        tick();
        chk("ar_new_drain", 32'(o_valid), 32'd0);

        // random valid/ready against the scoreboard
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = ($urandom_range(0, 3) != 0);
            i_data  = DATA_W'($urandom);
            i_ctrl  = CTRL_W'($urandom);
            chk("rnd_occ", 32'(o_occupancy), 32'(exp_q.size()));
            if (!o_valid) chk("rnd_bubble_ctrl", 32'(o_ctrl), 32'd0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) chk("rnd_underflow", 32'd1, 32'd0);
                else chk("rnd_order", 32'({o_ctrl, o_data}), 32'(exp_q.pop_front()));
            end
            if (i_valid && o_ready) exp_q.push_back({i_ctrl, i_data});
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (o_valid) begin
                if (exp_q.size() == 0) chk("drain_underflow", 32'd1, 32'd0);
                else chk("drain_order", 32'({o_ctrl, o_data}), 32'(exp_q.pop_front()));
            end
            tick();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
